// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StLoad,
        StChk,
        StDone,
        StErr
    } state_e;

    localparam int unsigned LEN_BYTES = 2;
    localparam int unsigned LEN_W     = 8 * LEN_BYTES;
    localparam logic [7:0]  CHK_SEED  = 8'h00;

endpackage

// File: rtl/imem_loader.sv
// Loads a framed byte stream (length, payload, XOR checksum) into the instruction memory
// through a byte-wide write port, stalling the core while a frame is in flight.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  cpu_stall,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           byte_count
);

    state_e                  state_q, state_d;
    logic [7:0]              len_hi_q, len_hi_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    accept;
    logic [LEN_W-1:0]        n_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_hi_q  <= '0;
            len_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        n_len     = {len_hi_q, in_data[7:0]};

        case (state_q)
            // A new start from DONE/ERR behaves exactly like one from IDLE.
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLenHi;
                    cnt_d   = '0;
                    acc_d   = DATA_WIDTH'(CHK_SEED);
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = in_data[7:0];
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = n_len;
                    if (n_len == '0 || 32'(n_len) > DEPTH) begin
                        state_d = StErr;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(cnt_q);
                    wr_data_d = in_data;
                    cnt_d     = cnt_q + 16'd1;
                    acc_d     = acc_q ^ in_data;
                    if (cnt_d == len_q) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    state_d = (in_data == acc_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready depends on state only, so at most one byte is taken per cycle.
    assign in_ready   = (state_q == StLenHi) || (state_q == StLenLo) ||
                        (state_q == StLoad)  || (state_q == StChk);
    assign accept     = in_valid && in_ready;
    assign busy       = in_ready;
    assign cpu_stall  = in_ready;
    assign done       = (state_q == StDone);
    assign err        = (state_q == StErr);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at accept time and
// compared (address, data, cycle) when wr_en fires.
module tb_imem_loader;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        cpu_stall;
    logic        done;
    logic        err;
    logic [15:0] byte_count;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  pl[$];
    logic [31:0] cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    logic [31:0] last_addr = 0;

    imem_loader #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(32),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .cpu_stall (cpu_stall),
        .done      (done),
        .err       (err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", exp_q.size(), 1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("wr_addr", wr_addr, e.addr);
                check_eq("wr_data", {24'h0, wr_data}, {24'h0, e.data});
                check_eq("wr_cycle", cyc, e.cyc);
                n_wr++;
                last_addr = wr_addr;
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input bit payload, input int unsigned idx,
                             input bit gap);
        int k = 0;
        wr_t e;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            check_eq("ready_timeout", {31'h0, in_ready}, 1);
        end else if (payload) begin
            e.cyc  = cyc + 1;
            e.addr = idx;
            e.data = b;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [7:0] chk, input bit gap,
                              input int start_at);
        bit ok;
        ok = (n != 0) && (n <= DEPTH);
        n_wr = 0;
        do_start();
        send_byte(n[15:8], 1'b0, 0, gap);
        send_byte(n[7:0], 1'b0, 0, gap);
        if (ok) begin
            for (int i = 0; i < int'(n); i++) begin
                if (i == start_at) start = 1'b1;
                send_byte(pl[i], 1'b1, i, gap);
            end
            send_byte(chk, 1'b0, 0, gap);
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [7:0] pl_xor();
        logic [7:0] x = 8'h00;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic check_result(input string tag, input bit exp_done, input bit exp_err,
                                input int exp_bc, input int exp_nwr);
        check_eq({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
        check_eq({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
        check_eq({tag, "_bc"}, {16'h0, byte_count}, exp_bc);
        check_eq({tag, "_stall"}, {31'h0, cpu_stall}, 0);
        check_eq({tag, "_busy"}, {31'h0, busy}, 0);
        check_eq({tag, "_nwr"}, n_wr, exp_nwr);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic load_nominal();
        pl.delete();
        pl.push_back(8'h13); pl.push_back(8'h05); pl.push_back(8'h00); pl.push_back(8'h00);
        pl.push_back(8'h93); pl.push_back(8'h05); pl.push_back(8'h10); pl.push_back(8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", {31'h0, in_ready}, 0);
        check_eq("rst_wr_en", {31'h0, wr_en}, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", {24'h0, wr_data}, 0);
        check_eq("rst_busy", {31'h0, busy}, 0);
        check_eq("rst_done", {31'h0, done}, 0);
        check_eq("rst_err", {31'h0, err}, 0);
        check_eq("rst_bc", {16'h0, byte_count}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame, valid held high throughout.
        load_nominal();
        check_eq("nom_chk_model", {24'h0, pl_xor()}, 32'h90);
        send_frame(16'd8, 8'h90, 1'b0, -1);
        check_result("nom", 1'b1, 1'b0, 8, 8);
        check_eq("nom_last_addr", last_addr, 7);

        // Valid left high in DONE: nothing consumed.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check_eq("done_hold_ready", {31'h0, in_ready}, 0);
            check_eq("done_hold_done", {31'h0, done}, 1);
        end
        in_valid = 1'b0;

        // Bad checksum.
        send_frame(16'd8, 8'h91, 1'b0, -1);
        check_result("badchk", 1'b0, 1'b1, 8, 8);

        // Length bounds.
        send_frame(16'd0, 8'h00, 1'b0, -1);
        check_result("len0", 1'b0, 1'b1, 0, 0);
        send_frame(16'd65, 8'h00, 1'b0, -1);
        check_result("len65", 1'b0, 1'b1, 0, 0);

        pl.delete();
        for (int i = 0; i < int'(DEPTH); i++) pl.push_back(8'((i * 7 + 3) & 8'hFF));
        send_frame(16'd64, pl_xor(), 1'b0, -1);
        check_result("len64", 1'b1, 1'b0, 64, 64);
        check_eq("len64_last_addr", last_addr, 63);

        // Gaps on alternate cycles.
        load_nominal();
        send_frame(16'd8, 8'h90, 1'b1, -1);
        check_result("gap", 1'b1, 1'b0, 8, 8);

        // Reset after three payload accepts.
        n_wr = 0;
        do_start();
        send_byte(8'h00, 1'b0, 0, 1'b0);
        send_byte(8'h08, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(pl[i], 1'b1, i, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_eq("mrst_wr_en", {31'h0, wr_en}, 0);
        check_eq("mrst_in_ready", {31'h0, in_ready}, 0);
        check_eq("mrst_busy", {31'h0, busy}, 0);
        check_eq("mrst_bc", {16'h0, byte_count}, 0);
        check_eq("mrst_nwr", n_wr, 3);
        check_eq("mrst_pending", exp_q.size(), 0);
        rst = 1'b0;
        @(negedge clk);
        send_frame(16'd8, 8'h90, 1'b0, -1);
        check_result("post_rst", 1'b1, 1'b0, 8, 8);

        // start pulsed during LOAD is ignored.
        send_frame(16'd8, 8'h90, 1'b0, 4);
        check_result("start_load", 1'b1, 1'b0, 8, 8);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
